// File: rtl/rx_fsm_receiver.sv
// rx_fsm_receiver: serial frame receiver (start, MSB-first data, even parity, stop bits) with held-word handshake; RX_SYNC_EN adds a two-flop Rx synchronizer
module rx_fsm_receiver #(
  parameter int STOP_BITS = 2,
  parameter int DATA_BITS = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 Rx_Ack,
  output logic [DATA_BITS-1:0] Rx_Data_Out,
  output logic                 Rx_Valid,
  output logic                 Parity_Error,
  output logic                 Framing_Error,
  output logic                 Overrun_Error,
  output logic                 RTS,
  output logic                 Rx_Busy
);
  localparam int MX = DATA_BITS > STOP_BITS ? DATA_BITS : STOP_BITS;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] sh;
  logic par, fe, rx_s, done, load, keep;
`ifdef RX_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer, idles high so reset does not fake a start bit
  always_ff @(posedge Clk) sync <= Rst ? 2'b11 : {sync[0], Rx};
  assign rx_s = sync[1];
`else
  assign rx_s = Rx;
`endif
  assign done = state == STOP && cnt == CW'(STOP_BITS - 1);
  assign load = done && (!Rx_Valid || Rx_Ack);
  assign keep = Rx_Valid && !Rx_Ack;
  // frame FSM plus held-word register and its status flags
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      fe <= 1'b0;
      Rx_Data_Out <= '0;
      Rx_Valid <= 1'b0;
      Parity_Error <= 1'b0;
      Framing_Error <= 1'b0;
      Overrun_Error <= 1'b0;
      RTS <= 1'b1;
      Rx_Busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!rx_s) begin
          state <= DATA;
          cnt <= '0;
          par <= 1'b0;
          fe <= 1'b0;
          Rx_Busy <= 1'b1;
        end
        DATA: begin
          sh <= DATA_BITS'({sh, rx_s});
          par <= par ^ rx_s;
          if (cnt == CW'(DATA_BITS - 1)) begin
            state <= PARITY;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        end
        PARITY: begin
          par <= par ^ rx_s;
          state <= STOP;
        end
        STOP: begin
          fe <= fe | !rx_s;
          if (done) begin
            state <= IDLE;
            cnt <= '0;
            Rx_Busy <= 1'b0;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
      Rx_Valid <= done || keep;
      RTS <= !(done || keep);
      if (load) begin
        Rx_Data_Out <= sh;
        Parity_Error <= par;
        Framing_Error <= fe | !rx_s;
        Overrun_Error <= 1'b0;
      end else if (done) Overrun_Error <= 1'b1;
      else if (Rx_Valid && Rx_Ack) begin
        Parity_Error <= 1'b0;
        Framing_Error <= 1'b0;
        Overrun_Error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rx_fsm_receiver.sv
// tb_rx_fsm_receiver: scoreboard bench for rx_fsm_receiver with directed frames
module tb_rx_fsm_receiver;
`ifdef RX_SYNC_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 11;
`endif
  logic Clk = 1'b0, Rst, Rx, Rx_Ack;
  logic [7:0] Rx_Data_Out;
  logic Rx_Valid, Parity_Error, Framing_Error, Overrun_Error, RTS, Rx_Busy;
  typedef struct {logic [7:0] d; logic pe; logic fe; logic ov; int t;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, checks = 0, errors = 0;
  logic pv = 1'b0;

  rx_fsm_receiver dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_Ack(Rx_Ack),
    .Rx_Data_Out(Rx_Data_Out), .Rx_Valid(Rx_Valid),
    .Parity_Error(Parity_Error), .Framing_Error(Framing_Error),
    .Overrun_Error(Overrun_Error), .RTS(RTS), .Rx_Busy(Rx_Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // monitor: latency on each fresh word, contents when the consumer acks it
  always @(negedge Clk) begin
    if (!Rst && Rx_Valid && !pv) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else if (q[0].t != 0) begin
        checks++;
        if (cyc != q[0].t) begin
          errors++;
          $display("FAIL latency got cycle %0d exp %0d", cyc, q[0].t);
        end
      end
    end
    if (!Rst && Rx_Valid && Rx_Ack && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({Rx_Data_Out, Parity_Error, Framing_Error, Overrun_Error, RTS} != {e.d, e.pe, e.fe, e.ov, 1'b0}) begin
        errors++;
        $display("FAIL word got d=%h pe=%b fe=%b ov=%b rts=%b exp d=%h pe=%b fe=%b ov=%b rts=0",
                 Rx_Data_Out, Parity_Error, Framing_Error, Overrun_Error, RTS, e.d, e.pe, e.fe, e.ov);
      end
    end
    pv = Rx_Valid;
  end

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, g, x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
      Rx = 1'b1;
      Rx_Ack = 1'b0;
    end
  endtask

  task automatic ack();
    @(posedge Clk); #1;
    Rx = 1'b1;
    Rx_Ack = 1'b1;
    @(posedge Clk); #1;
    Rx_Ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s1, input logic s2, input int ack_at,
                      input bit push, input logic pe, input logic fe, input logic ov, input bit tchk);
    logic [11:0] b;
    b = {1'b0, d, p, s1, s2};
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      Rx = b[11-i];
      Rx_Ack = (i == ack_at);
      if (i == 0 && push) q.push_back('{d, pe, fe, ov, tchk ? cyc + 1 + LAT : 0});
    end
  endtask

  initial begin
    Rst = 1'b1;
    Rx = 1'b1;
    Rx_Ack = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid", Rx_Valid, 0);
    chk("rst_rts", RTS, 1);
    chk("rst_busy", Rx_Busy, 0);
    chk("rst_data", Rx_Data_Out, 0);
    chk("rst_flags", {Parity_Error, Framing_Error, Overrun_Error}, 0);
    Rst = 1'b0;
    idle(2);
    ack();
    chk("idle_ack_valid", Rx_Valid, 0);
    chk("idle_ack_rts", RTS, 1);
    send(8'hA5, 1'b0, 1'b1, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0, 1);
    chk("busy_in_stop", Rx_Busy, 1);
    idle(3);
    chk("a5_rts_low", RTS, 0);
    chk("a5_busy_idle", Rx_Busy, 0);
    ack();
    idle(1);
    chk("a5_rts_back", RTS, 1);
    send(8'h01, 1'b0, 1'b1, 1'b1, -1, 1, 1'b1, 1'b0, 1'b0, 1);
    idle(3);
    ack();
    idle(1);
    send(8'h3C, 1'b0, 1'b1, 1'b0, -1, 1, 1'b0, 1'b1, 1'b0, 1);
    send(8'h81, 1'b0, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1);
    idle(3);
    ack();
    idle(1);
    send(8'h11, 1'b0, 1'b1, 1'b1, -1, 1, 1'b0, 1'b0, 1'b1, 1);
    send(8'h22, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    chk("overrun_flag", Overrun_Error, 1);
    chk("overrun_keep", Rx_Data_Out, 8'h11);
    ack();
    idle(1);
    chk("ovr_ack_valid", Rx_Valid, 0);
    chk("ovr_ack_flags", {Parity_Error, Framing_Error, Overrun_Error}, 0);
    chk("ovr_ack_rts", RTS, 1);
    send(8'h33, 1'b0, 1'b1, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0, 1);
    idle(2);
    send(8'h44, 1'b0, 1'b1, 1'b1, 11, 1, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    chk("same_edge_valid", Rx_Valid, 1);
    chk("same_edge_data", Rx_Data_Out, 8'h44);
    chk("same_edge_ov", Overrun_Error, 0);
    ack();
    idle(1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      Rx = (i == 0) ? 1'b0 : 1'b1;
      Rst = (i == 4);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    Rx = 1'b1;
    idle(20);
    chk("abort_valid", Rx_Valid, 0);
    chk("abort_busy", Rx_Busy, 0);
    send(8'h5A, 1'b0, 1'b1, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0, 1);
    idle(3);
    chk("5a_data", Rx_Data_Out, 8'h5A);
    ack();
    idle(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_fsm_receiver.md
RX_FSM_RECEIVER -- requirements
Module: rx_fsm_receiver

Interface
REQ-001 SHALL have parameter STOP_BITS, default 2, number of stop bits per frame (>=1).
REQ-002 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (>=1).
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port Rx, input, 1, serial line, idle high.
REQ-006 SHALL have port Rx_Ack, input, 1, consumer acknowledge of held word.
REQ-007 SHALL have port Rx_Data_Out, output, DATA_BITS, last received data word.
REQ-008 SHALL have port Rx_Valid, output, 1, held word available.
REQ-009 SHALL have port Parity_Error, output, 1, held word failed even-parity check.
REQ-010 SHALL have port Framing_Error, output, 1, held word had >=1 stop bit sampled low.
REQ-011 SHALL have port Overrun_Error, output, 1, a frame was dropped while word was held.
REQ-012 SHALL have port RTS, output, 1, ready-to-send to the far transmitter's CTS.
REQ-013 SHALL have port Rx_Busy, output, 1, high while a frame is being received.

Function
REQ-014 Frame format SHALL be: start bit 0, data MSB first, parity bit, STOP_BITS stop bits of 1; one bit per Clk cycle, no baud divider.
REQ-015 Parity SHALL be even: error when XOR of data bits and the parity bit is 1.
REQ-016 States SHALL be IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: Rx sampled 0 -> DATA; otherwise stay IDLE.
REQ-018 DATA: sample one data bit per cycle, MSB first; after DATA_BITS samples -> PARITY.
REQ-019 PARITY: sample the parity bit for one cycle -> STOP.
REQ-020 STOP: sample STOP_BITS bits; after the last one -> IDLE.
REQ-021 At the edge sampling the last stop bit, if Rx_Valid is 0: load Rx_Data_Out, Parity_Error, Framing_Error and set Rx_Valid.
REQ-022 Latency: Rx_Valid SHALL be visible DATA_BITS+STOP_BITS+1 cycles after the start-bit sampling edge (11 at defaults).
REQ-023 Rx_Valid, Rx_Data_Out and both error flags SHALL hold until an edge with Rx_Ack=1, which clears Rx_Valid, Parity_Error, Framing_Error and Overrun_Error.
REQ-024 Rx_Ack while Rx_Valid=0 SHALL have no effect.
REQ-025 Frame completing while Rx_Valid=1 and Rx_Ack=0: held word unchanged, new word discarded, Overrun_Error set, sticky until acked.
REQ-026 Frame completing on the same edge as Rx_Ack=1: held word cleared and new word loaded; Rx_Valid stays 1; no overrun.
REQ-027 Back-to-back: a start bit SHALL be accepted on the cycle immediately after the last stop-bit sample.
REQ-028 A stop bit sampled 0 SHALL NOT abort the frame; all stop bits are still consumed (an all-zero break gives Framing_Error).
REQ-029 RTS SHALL equal !Rx_Valid, registered.
REQ-030 Rx_Busy SHALL be 1 in DATA, PARITY and STOP; 0 in IDLE.

Reset
REQ-031 Rst=1 at an edge: state IDLE, Rx_Data_Out 0, Rx_Valid 0, all error flags 0, Rx_Busy 0, RTS 1.
REQ-032 Reset mid-frame SHALL discard the partial frame, with no Rx_Valid pulse.
REQ-033 Reset SHALL take priority over Rx_Ack and frame completion on the same edge.

Configuration
REQ-034 Macro RX_SYNC_EN defined: Rx passes through a two-flop synchronizer (reset to 1) before the FSM; all latencies grow by 2 cycles.
REQ-035 RX_SYNC_EN undefined: FSM samples Rx directly, with the latencies stated above.

Verification
REQ-036 Defaults, frame 0xA5 with parity 0 and stops 11 -> Rx_Data_Out=0xA5, Rx_Valid=1 at start+11, no errors, RTS=0.
REQ-037 Frame 0x01 with parity bit 0 -> Rx_Valid=1, Rx_Data_Out=0x01, Parity_Error=1, Framing_Error=0.
REQ-038 Frame 0x3C with second stop bit 0 -> Framing_Error=1; next start accepted immediately after.
REQ-039 Frames 0x11 then 0x22 with no Rx_Ack -> Rx_Data_Out=0x11, Overrun_Error=1; Rx_Ack clears all flags and RTS returns to 1.
REQ-040 Rst pulsed at data bit 4 of 0xFF, then clean frame 0x5A -> no Rx_Valid for the aborted frame; 0x5A received correctly.
REQ-041 RX_SYNC_EN defined, frame 0xA5 -> Rx_Valid at start+13.
